// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with a one-entry holding
// register in front of the shift register. Frames carry 1 start bit,
// DATA_BITS data bits (LSB first), an optional parity bit and one or two
// stop bits. If the next word is already held, frames go out back-to-back.
module uart_tx_frame #(
  parameter int CLK_DIV   = 5208,  // sclk cycles per bit, 2..8191
  parameter int DATA_BITS = 8,     // payload width, 5..9
  parameter int PARITY    = 0,     // 0 none, 1 odd, 2 even
  parameter int STOP_BITS = 1      // 1 or 2
) (
  input  logic                 sclk,
  input  logic                 rst_n,
  input  logic                 pi_valid,
  input  logic [DATA_BITS-1:0] pi_data,
  output logic                 pi_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  localparam logic [12:0] DIV_LAST  = 13'(CLK_DIV - 1);
  localparam logic [12:0] DIV_PRE   = 13'(CLK_DIV - 2);
  localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

  state_t                 r_state;
  logic [12:0]            r_cnt;
  logic [3:0]             r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par;
  logic [DATA_BITS-1:0]   r_hold;
  logic                   r_hold_full;
  logic                   r_tx;
  logic                   r_busy;
  logic                   r_done;

  logic w_bit_tick;
  logic w_last_stop;
  logic w_load;
  logic w_accept;
  logic w_hold_par;

  assign w_bit_tick  = (r_cnt == DIV_LAST);
  assign w_last_stop = (r_state == S_STOP) && (r_bit_idx == STOP_LAST);
  // Hold moves into the shift register from IDLE, or at the very end of the
  // last stop bit so the next start bit follows with no idle cycle.
  assign w_load      = r_hold_full && ((r_state == S_IDLE) || (w_last_stop && w_bit_tick));
  // pi_ready is low while hold is full, so an accept never meets a load.
  assign w_accept    = pi_valid && !r_hold_full;
  // Parity is taken from the word as loaded, before any bits are shifted out.
  assign w_hold_par  = (PARITY == 2) ? (^r_hold) : (~^r_hold);

  assign pi_ready = ~r_hold_full;
  assign tx       = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;

  // Holding register: capture on accept, release when the FSM takes the word.
  // NOTE: the data register is reset too, so a word held when reset hits is
  // discarded rather than lingering as stale contents.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= pi_data;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  // Baud counter: free-runs 0..CLK_DIV-1 while a frame is active, parked in IDLE.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((r_state == S_IDLE) || w_bit_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 13'd1;
    end
  end

  // Frame FSM with registered tx/busy/done; all bit changes happen on bit_tick.
  // NOTE: every register here uses <= so all of them see the pre-edge values
  // of each other, exactly like the flops they become.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // done is set one cycle early so it is high in the final stop cycle.
      r_done <= w_last_stop && (r_cnt == DIV_PRE);
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_state <= S_START;
            r_shift <= r_hold;
            r_par   <= w_hold_par;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_tick) begin
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (w_bit_tick) begin
            if (r_bit_idx == DATA_LAST) begin
              r_bit_idx <= '0;
              if (PARITY != 0) begin
                r_state <= S_PAR;
                r_tx    <= r_par;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
        end
        S_PAR: begin
          if (w_bit_tick) begin
            r_state   <= S_STOP;
            r_tx      <= 1'b1;
            r_bit_idx <= '0;
          end
        end
        S_STOP: begin
          if (w_bit_tick) begin
            if (r_bit_idx == STOP_LAST) begin
              r_bit_idx <= '0;
              if (w_load) begin
                r_state <= S_START;
                r_shift <= r_hold;
                r_par   <= w_hold_par;
                r_tx    <= 1'b0;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises words of configurable width with optional parity and one or two stop bits. Upstream uses a valid/ready handshake backed by a one-entry holding register, so frames can be sent back-to-back with no idle gap. Sits between on-chip producers (e.g. the image-processing result path) and the board's serial TX pin, at the same clock as the rest of the design.

## Interface
- CLK_DIV, 5208: sclk cycles per bit; legal range 2..8191 (13-bit counter).
- DATA_BITS, 8: payload width; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

- sclk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pi_valid  in  1  producer has a word on pi_data.
- pi_data  in  DATA_BITS  word to send; sampled only on accept.
- pi_ready  out  1  combinational, = ~hold_full; accept happens on an edge where pi_valid & pi_ready.
- tx  out  1  serial line, idle high; registered.
- busy  out  1  registered; high while the FSM is not in IDLE.
- done  out  1  registered one-cycle pulse in the last cycle of the final stop bit.

## Operation
- Reset values: tx=1, busy=0, done=0, hold_full=0 (pi_ready=1), FSM=IDLE, baud counter=0, bit index=0.
- Holding register: on accept, pi_data is loaded into hold and hold_full is set. hold_full clears when the FSM moves the word into the shift register. An accept cannot coincide with a transfer, because pi_ready is low whenever hold is full.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: when hold_full=1, go to START, tx<=0, shift<=hold, clear hold_full.
  - START: after one bit time, go to DATA and drive bit 0.
  - DATA: shift out LSB first. After DATA_BITS bit times, go to PAR if PARITY!=0, otherwise go to STOP.
  - PAR: drive ^shift_orig for even parity or ~^shift_orig for odd parity, for one bit time, then go to STOP.
  - STOP: tx=1 for STOP_BITS bit times.
    - At the end, if hold_full=1, go directly to START. tx<=0 on that same edge, with no idle cycle.
    - Otherwise go to IDLE.
- Baud counter: counts 0..CLK_DIV-1 while busy and is held at 0 in IDLE. bit_tick = (cnt==CLK_DIV-1). Every state transition and tx change after the first occurs on bit_tick.
- Every bit, including each stop bit, lasts exactly CLK_DIV cycles.
- Frame length = CLK_DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
- done is asserted in the cycle where the FSM is in STOP, on the last stop bit, and bit_tick=1. busy stays high during that cycle.
- Reset asserted mid-frame: the frame is aborted, all registers return to reset values asynchronously, tx=1 immediately, and the held word is discarded.
- pi_data changes while hold_full=1 have no effect.

## Timing
- Accept on edge N. hold_full=1 after edge N. Edge N+1: START, tx=0, busy=1. Start-to-line latency is 2 edges from an idle state.
- pi_ready falls after the accept edge and rises after the edge that transfers hold into the shift register.
- Back-to-back:
  - The second word may be accepted any time after the first word's transfer.
  - The second start bit begins on the edge following the last stop-bit cycle.
  - busy remains high throughout.
  - done pulses once per frame.
- Throughput: one frame per frame-length cycles when the producer keeps hold full.

## Test plan
- CLK_DIV=4, DATA_BITS=8, PARITY=0, STOP_BITS=1; send 0xA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. tx low on edge N+1. done pulses at cycle 40 of the frame, then busy=0.
- Same configuration with PARITY=2, then PARITY=1; send 0xA5 -> parity bit 0 (even) and 1 (odd); frame length 44 cycles.
- DATA_BITS=7, PARITY=0, STOP_BITS=2; send 0x7F -> 0, seven 1s, stop high for 8 cycles; done only at the end of the second stop bit.
- Hold pi_valid high with 0x00, then 0xFF -> second start bit immediately follows the first stop bit with zero idle cycles. pi_ready goes 1→0→1 per frame. Exactly two done pulses.
- Assert rst_n=0 during DATA bit 3 while a second word is held -> tx=1, busy=0, pi_ready=1 asynchronously. After release, the line stays idle and the held word is not sent.
- Idle with pi_valid=0 for 100 cycles -> tx=1, busy=0, counter stays 0, no done pulse.
